seven_seg_scan_decoder: RTL and testbench
=========================================

# seven_seg_scan_decoder

Receive-side counterpart of the multiplexed two-digit seven-segment driver. Samples the scanned segment bus and digit enables, filters scan transients, decodes each glyph back to a 4-bit value, and presents stable left and right digit values with valid, update and error indications. Used as an on-chip loopback checker behind the display driver and as a board-to-board display snooper.

## Interface

Parameters:
- `STABLE_CYCLES`, default 4: consecutive identical samples (same enable, same segments) needed to accept a glyph; legal range 1–255.
- `TIMEOUT_CYCLES`, default 65535: cycles without an accepted glyph before that digit's valid drops; legal range 1–65535.

Ports:
- `clk`, input, 1: system clock.
- `reset`, input, 1: asynchronous, active-low reset.
- `SevenSegIn`, input, 7: segment bus, active-high; bit6 = a … bit0 = g.
- `EnableIn`, input, 2: digit select, active-high one-hot; bit1 = left, bit0 = right.
- `Ldigit`, output, 4: last accepted left value.
- `Rdigit`, output, 4: last accepted right value.
- `Lvalid`, output, 1: left value is current (not blank, not timed out).
- `Rvalid`, output, 1: right value is current.
- `Update`, output, 1: one-cycle pulse on any accepted glyph (value or blank).
- `GlyphErr`, output, 1: one-cycle pulse when a stable, non-blank pattern is not in the glyph table.
- `ErrCount`, output, 8: saturating count of GlyphErr pulses. Present only with `SEG_SCAN_ERR_CNT_EN`.

## Operation

- **Stage 0.** `SevenSegIn` and `EnableIn` are registered into `s_seg` and `s_en` every cycle.
- **Stability counter `stab` (8 bits).**
  - Cleared when `s_en` is not one-hot (00 or 11), or when `{s_seg,s_en}` differs from the previous cycle's value.
  - Otherwise increments and saturates at `STABLE_CYCLES`.
- **Accept.** Fires in the cycle `stab` first reaches `STABLE_CYCLES`. It fires once per dwell; re-arm requires a change or a non-one-hot enable.
- **Glyph table (hex 0–F):** 7E, 30, 6D, 79, 33, 5B, 5F, 70, 7F, 7B, 77, 1F, 4E, 3D, 4F, 47.
- **On accept, by pattern:**
  - Table hit: selected digit register ← value, its valid ← 1, `Update` pulses.
  - Pattern 00 (blank): selected valid ← 0, digit register keeps its old value, `Update` pulses, no error.
  - Any other pattern: `GlyphErr` pulses, digit register and valid are unchanged, no `Update`.
- **Per-digit timeout counter (16 bits).**
  - Cleared on any accept to that digit, including error accepts.
  - Otherwise increments and saturates.
  - On reaching `TIMEOUT_CYCLES`, that digit's valid ← 0.
  - If the accept and the timeout land in the same cycle, the accept wins.
- **Reset.** All outputs, `s_seg`, `s_en`, `stab` and both timeout counters go to 0. A reset mid-dwell discards partial stability.

## Timing

- Latency: a pattern first present at the input in cycle n is accepted at the end of cycle n+`STABLE_CYCLES` (one sample stage plus the count). Outputs change at that edge.
- `Update` and `GlyphErr` are registered pulses, exactly one cycle wide, and never both high.
- Per-digit timing is independent: a left accept does not touch the right timeout counter.
- A dwell shorter than `STABLE_CYCLES` produces no output change.
- `STABLE_CYCLES` = 1 accepts on the first registered sample.

## Configuration

- `SEG_SCAN_ERR_CNT_EN` defined: `ErrCount` port and an 8-bit saturating counter are present; the counter increments on each `GlyphErr` and holds at 255.
- Undefined: the port and the counter are absent; `GlyphErr` behaviour is unchanged.

## Structure

- Shared package `seg_scan_pkg`:
  - 16-entry glyph constant array.
  - Blank constant 7'h00.
  - Enable bit positions (LEFT = 1, RIGHT = 0).
- Sub-module `seg_glyph_lookup`: combinational map from 7-bit pattern to {hit, blank, value[3:0]}. Reused by the display-driver testbench.

## Test plan

- **Basic decode.** EnableIn=10, SevenSegIn=6D held 6 cycles, `STABLE_CYCLES`=4 → Ldigit=2, Lvalid=1, one `Update` pulse in cycle 4 after the first sample. Rdigit and Rvalid stay 0.
- **Alternating scan.** Alternating 8-cycle dwells: left 7E (0), right 47 (F) → Ldigit=0, Rdigit=F, both valid, `Update` every 8 cycles, no repeat pulses within a dwell.
- **Glitch rejection.** Inject a 3-cycle 7F between dwells, plus EnableIn=11 for 5 cycles → no `Update`, digits unchanged.
- **Bad glyph.** Left pattern 01 held 4 cycles → one `GlyphErr`, Ldigit and Lvalid unchanged. `ErrCount`=1 with the macro defined; 256 errors → `ErrCount`=255.
- **Blank and timeout.** Right digit 30 accepted, then right blank 00 → Rvalid=0, Rdigit=1. Separately, `TIMEOUT_CYCLES`=20 with left scanning stopped → Lvalid falls exactly 20 cycles after the last left accept.
- **Reset mid-dwell.** Reset asserted after 2 stable cycles → all outputs 0 immediately; after release the same pattern needs a full `STABLE_CYCLES` again.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared definitions for the seven-segment scan decoder: glyph table,
// blank pattern, digit-enable bit positions and the lookup result type.
package seg_scan_pkg;

    // Segment patterns for hex 0..F, bit6 = a ... bit0 = g; entry i is value i
    localparam logic [15:0][6:0] GLYPHS = {
        7'h47, 7'h4F, 7'h3D, 7'h4E,   // F E D C
        7'h1F, 7'h77, 7'h7B, 7'h7F,   // B A 9 8
        7'h70, 7'h5F, 7'h5B, 7'h33,   // 7 6 5 4
        7'h79, 7'h6D, 7'h30, 7'h7E    // 3 2 1 0
    };

    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam int EN_LEFT  = 1;
    localparam int EN_RIGHT = 0;

    typedef struct packed {
        logic       hit;
        logic       blank;
        logic [3:0] value;
    } glyph_info_t;

endpackage

// File: rtl/seg_glyph_lookup.sv
// Combinational reverse map from a 7-bit segment pattern to its hex value,
// flagging table hits and the blank pattern separately.
module seg_glyph_lookup
    import seg_scan_pkg::*;
(
    input  logic [6:0]  pattern,
    output glyph_info_t info
);

    // Search the glyph table; the blank pattern is never a table entry
    always_comb begin
        info.hit   = 1'b0;
        info.blank = (pattern == SEG_BLANK);
        info.value = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (pattern == GLYPHS[i]) begin
                info.hit   = 1'b1;
                info.value = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Receive side of the multiplexed two-digit seven-segment display: filters
// scan transients and recovers stable left/right digit values.
// Optional feature macro: SEG_SCAN_ERR_CNT_EN adds the ErrCount port and an
// 8-bit saturating count of GlyphErr pulses.
module seven_seg_scan_decoder
    import seg_scan_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] SevenSegIn,
    input  logic [1:0] EnableIn,
    output logic [3:0] Ldigit,
    output logic [3:0] Rdigit,
    output logic       Lvalid,
    output logic       Rvalid,
    output logic       Update,
    output logic       GlyphErr
`ifdef SEG_SCAN_ERR_CNT_EN
    ,
    output logic [7:0] ErrCount
`endif
);

    localparam logic [7:0]  STAB_TARGET   = 8'(STABLE_CYCLES);
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    logic [6:0]  s_seg;
    logic [6:0]  p_seg;
    logic [1:0]  s_en;
    logic [1:0]  p_en;
    logic [7:0]  stab;
    logic [7:0]  stab_next;
    logic        one_hot;
    logic        same;
    logic        accept;
    logic        accept_left;
    logic        accept_right;
    logic        glyph_bad;
    logic [15:0] tmo_left;
    logic [15:0] tmo_right;
    logic [15:0] tmo_left_inc;
    logic [15:0] tmo_right_inc;
    glyph_info_t glyph;

    seg_glyph_lookup u_lookup (
        .pattern (s_seg),
        .info    (glyph)
    );

    // Sample the bus, and keep the previous sample for change detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_seg <= '0;
            s_en  <= '0;
            p_seg <= '0;
            p_en  <= '0;
        end else begin
            s_seg <= SevenSegIn;
            s_en  <= EnableIn;
            p_seg <= s_seg;
            p_en  <= s_en;
        end
    end

    assign one_hot = ^s_en;
    assign same    = ({s_seg, s_en} == {p_seg, p_en});

    // stab is the length of the current run of identical one-hot samples;
    // accept fires only on the sample that first completes the run
    always_comb begin
        stab_next = '0;
        accept    = 1'b0;
        if (one_hot) begin
            if (!same) begin
                stab_next = 8'd1;
            end else if (stab != STAB_TARGET) begin
                stab_next = stab + 8'd1;
            end else begin
                stab_next = stab;
            end
            accept = (stab_next == STAB_TARGET) && !(same && (stab == STAB_TARGET));
        end
    end

    // Stability run-length register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stab <= '0;
        end else begin
            stab <= stab_next;
        end
    end

    assign accept_left   = accept && s_en[EN_LEFT];
    assign accept_right  = accept && s_en[EN_RIGHT];
    assign glyph_bad     = accept && !glyph.hit && !glyph.blank;
    assign tmo_left_inc  = (tmo_left  == 16'hFFFF) ? tmo_left  : tmo_left  + 16'd1;
    assign tmo_right_inc = (tmo_right == 16'hFFFF) ? tmo_right : tmo_right + 16'd1;

    // Registered one-cycle indications; blanks update but never error
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Update   <= 1'b0;
            GlyphErr <= 1'b0;
        end else begin
            Update   <= accept && (glyph.hit || glyph.blank);
            GlyphErr <= glyph_bad;
        end
    end

    // Left digit value, valid flag and inactivity timeout; accept beats timeout
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Ldigit   <= '0;
            Lvalid   <= 1'b0;
            tmo_left <= '0;
        end else if (accept_left) begin
            tmo_left <= '0;
            if (glyph.hit) begin
                Ldigit <= glyph.value;
                Lvalid <= 1'b1;
            end else if (glyph.blank) begin
                Lvalid <= 1'b0;
            end
        end else begin
            tmo_left <= tmo_left_inc;
            if (tmo_left_inc == TIMEOUT_LIMIT) begin
                Lvalid <= 1'b0;
            end
        end
    end

    // Right digit value, valid flag and inactivity timeout; accept beats timeout
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Rdigit    <= '0;
            Rvalid    <= 1'b0;
            tmo_right <= '0;
        end else if (accept_right) begin
            tmo_right <= '0;
            if (glyph.hit) begin
                Rdigit <= glyph.value;
                Rvalid <= 1'b1;
            end else if (glyph.blank) begin
                Rvalid <= 1'b0;
            end
        end else begin
            tmo_right <= tmo_right_inc;
            if (tmo_right_inc == TIMEOUT_LIMIT) begin
                Rvalid <= 1'b0;
            end
        end
    end

`ifdef SEG_SCAN_ERR_CNT_EN
    // Saturating count of unrecognised stable glyphs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ErrCount <= '0;
        end else if (glyph_bad && (ErrCount != 8'hFF)) begin
            ErrCount <= ErrCount + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Directed self-checking bench for seven_seg_scan_decoder: a main instance
// (STABLE_CYCLES=4, TIMEOUT_CYCLES=20) and a second instance with
// STABLE_CYCLES=1 for the minimum-filter boundary.
module tb_seven_seg_scan_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] seg_in;
    logic [1:0] en_in;
    logic [3:0] Ldigit;
    logic [3:0] Rdigit;
    logic       Lvalid;
    logic       Rvalid;
    logic       Update;
    logic       GlyphErr;

    logic [6:0] seg_b;
    logic [1:0] en_b;
    logic [3:0] ldigit_b;
    logic [3:0] rdigit_b;
    logic       lvalid_b;
    logic       rvalid_b;
    logic       update_b;
    logic       glyph_err_b;

`ifdef SEG_SCAN_ERR_CNT_EN
    logic [7:0] ErrCount;
    logic [7:0] err_count_b;
`endif

    int check_count = 0;
    int fail_count  = 0;
    int upd_seen    = 0;
    int err_seen    = 0;
    int k;

    always #5 clk = ~clk;

    seven_seg_scan_decoder #(
        .STABLE_CYCLES  (4),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .SevenSegIn (seg_in),
        .EnableIn   (en_in),
        .Ldigit     (Ldigit),
        .Rdigit     (Rdigit),
        .Lvalid     (Lvalid),
        .Rvalid     (Rvalid),
        .Update     (Update),
        .GlyphErr   (GlyphErr)
`ifdef SEG_SCAN_ERR_CNT_EN
        ,
        .ErrCount   (ErrCount)
`endif
    );

    seven_seg_scan_decoder #(
        .STABLE_CYCLES  (1),
        .TIMEOUT_CYCLES (65535)
    ) dut_fast (
        .clk        (clk),
        .reset      (reset),
        .SevenSegIn (seg_b),
        .EnableIn   (en_b),
        .Ldigit     (ldigit_b),
        .Rdigit     (rdigit_b),
        .Lvalid     (lvalid_b),
        .Rvalid     (rvalid_b),
        .Update     (update_b),
        .GlyphErr   (glyph_err_b)
`ifdef SEG_SCAN_ERR_CNT_EN
        ,
        .ErrCount   (err_count_b)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [6:0] seg, input logic [1:0] en, input int cycles);
        seg_in = seg;
        en_in  = en;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clearPulses();
        upd_seen = 0;
        err_seen = 0;
    endtask

    // Count pulses mid-cycle and flag any cycle where both indications are high
    always @(negedge clk) begin
        if (Update) upd_seen++;
        if (GlyphErr) err_seen++;
        if (Update && GlyphErr) checkOutput("pulse_exclusive", 32'(Update && GlyphErr), 32'd0);
    end

    initial begin
        reset  = 1'b0;
        seg_in = '0;
        en_in  = '0;
        seg_b  = '0;
        en_b   = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_ldigit", 32'(Ldigit), 32'd0);
        checkOutput("reset_rdigit", 32'(Rdigit), 32'd0);
        checkOutput("reset_lvalid", 32'(Lvalid), 32'd0);
        checkOutput("reset_rvalid", 32'(Rvalid), 32'd0);
        checkOutput("reset_update", 32'(Update), 32'd0);
        checkOutput("reset_glypherr", 32'(GlyphErr), 32'd0);
        reset = 1'b1;

        $display("[TB] basic decode");
        seg_in = 7'h6D;
        en_in  = 2'b10;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("basic_update_c%0d", c), 32'(Update), 32'(c == 5));
        end
        checkOutput("basic_ldigit", 32'(Ldigit), 32'h2);
        checkOutput("basic_lvalid", 32'(Lvalid), 32'd1);
        checkOutput("basic_rdigit", 32'(Rdigit), 32'd0);
        checkOutput("basic_rvalid", 32'(Rvalid), 32'd0);

        $display("[TB] alternating scan");
        for (int d = 0; d < 4; d++) begin
            clearPulses();
            if (d % 2 == 0) applyStimulus(7'h7E, 2'b10, 8);
            else            applyStimulus(7'h47, 2'b01, 8);
            checkOutput($sformatf("alt_updates_d%0d", d), 32'(upd_seen), 32'd1);
        end
        checkOutput("alt_ldigit", 32'(Ldigit), 32'h0);
        checkOutput("alt_rdigit", 32'(Rdigit), 32'hF);
        checkOutput("alt_lvalid", 32'(Lvalid), 32'd1);
        checkOutput("alt_rvalid", 32'(Rvalid), 32'd1);

        $display("[TB] bad glyph");
        clearPulses();
        applyStimulus(7'h01, 2'b10, 4);
        applyStimulus(7'h00, 2'b00, 2);
        checkOutput("bad_errs", 32'(err_seen), 32'd1);
        checkOutput("bad_updates", 32'(upd_seen), 32'd0);
        checkOutput("bad_ldigit", 32'(Ldigit), 32'h0);
        checkOutput("bad_lvalid", 32'(Lvalid), 32'd1);
`ifdef SEG_SCAN_ERR_CNT_EN
        checkOutput("bad_errcount", 32'(ErrCount), 32'd1);
`endif

        $display("[TB] glitch rejection");
        clearPulses();
        applyStimulus(7'h7F, 2'b10, 3);
        applyStimulus(7'h7E, 2'b11, 5);
        checkOutput("glitch_updates", 32'(upd_seen), 32'd0);
        checkOutput("glitch_errs", 32'(err_seen), 32'd0);
        checkOutput("glitch_ldigit", 32'(Ldigit), 32'h0);
        checkOutput("glitch_rdigit", 32'(Rdigit), 32'hF);
        checkOutput("glitch_lvalid", 32'(Lvalid), 32'd1);
        checkOutput("glitch_rvalid", 32'(Rvalid), 32'd1);

        $display("[TB] blank");
        clearPulses();
        applyStimulus(7'h30, 2'b01, 8);
        checkOutput("blank_pre_updates", 32'(upd_seen), 32'd1);
        checkOutput("blank_pre_rdigit", 32'(Rdigit), 32'h1);
        checkOutput("blank_pre_rvalid", 32'(Rvalid), 32'd1);
        clearPulses();
        applyStimulus(7'h00, 2'b01, 8);
        checkOutput("blank_updates", 32'(upd_seen), 32'd1);
        checkOutput("blank_errs", 32'(err_seen), 32'd0);
        checkOutput("blank_rvalid", 32'(Rvalid), 32'd0);
        checkOutput("blank_rdigit", 32'(Rdigit), 32'h1);

        $display("[TB] timeout");
        applyStimulus(7'h5B, 2'b10, 4);
        seg_in = 7'h00;
        en_in  = 2'b00;
        @(posedge clk);
        #1;
        checkOutput("tmo_ldigit", 32'(Ldigit), 32'h5);
        checkOutput("tmo_lvalid", 32'(Lvalid), 32'd1);
        k = 0;
        while (Lvalid && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        checkOutput("tmo_cycles", 32'(k), 32'd20);
        checkOutput("tmo_rdigit", 32'(Rdigit), 32'h1);

        $display("[TB] reset mid-dwell");
        seg_in = 7'h79;
        en_in  = 2'b10;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        #1;
        checkOutput("rst_ldigit", 32'(Ldigit), 32'd0);
        checkOutput("rst_rdigit", 32'(Rdigit), 32'd0);
        checkOutput("rst_lvalid", 32'(Lvalid), 32'd0);
        checkOutput("rst_update", 32'(Update), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("rst_update_c%0d", c), 32'(Update), 32'(c == 5));
        end
        checkOutput("rst_after_ldigit", 32'(Ldigit), 32'h3);
        checkOutput("rst_after_lvalid", 32'(Lvalid), 32'd1);

        $display("[TB] single-cycle filter");
        seg_b = 7'h30;
        en_b  = 2'b10;
        @(posedge clk);
        #1;
        checkOutput("fast_update_c1", 32'(update_b), 32'd0);
        seg_b = 7'h00;
        en_b  = 2'b00;
        @(posedge clk);
        #1;
        checkOutput("fast_update_c2", 32'(update_b), 32'd1);
        checkOutput("fast_ldigit", 32'(ldigit_b), 32'h1);
        checkOutput("fast_lvalid", 32'(lvalid_b), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("fast_update_c3", 32'(update_b), 32'd0);

`ifdef SEG_SCAN_ERR_CNT_EN
        $display("[TB] error counter saturation");
        for (int e = 0; e < 260; e++) begin
            applyStimulus(7'h01, 2'b10, 4);
            applyStimulus(7'h00, 2'b00, 1);
        end
        checkOutput("errcount_sat", 32'(ErrCount), 32'd255);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
        $finish;
    end

endmodule
